piso_serializer: RTL and testbench

Parallel-in, serial-out frame serializer: the transmit end feeding the team's serial shift-register chains. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on SO, one bit per `clken` strobe. It reports frame completion with a one-cycle pulse. It sits between a parallel data source and any serial-in consumer.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer_if.sv | 22 ++
 rtl/piso_serializer.sv | 108 ++++++++++
 tb/tb_piso_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO frame serializer.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // Bit counter width; WIDTH is at least 2, so this is never zero.
    function automatic int piso_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle between a word source and the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 32
);
    logic             clken;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             SO;
    logic             busy;
    logic             done;

    modport master (
        output clken, load_valid, din,
        input  load_ready, SO, busy, done
    );

    modport slave (
        input  clken, load_valid, din,
        output load_ready, SO, busy, done
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out frame serializer, MSB first, one bit per clken strobe.
// Optional even-parity trailer bit is built when PISO_PARITY_EN is defined.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);

    localparam int CNT_W = piso_cnt_w(WIDTH);

    piso_state_e        state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               done_q,  done_d;
    logic               accept;
    logic               last_bit;
`ifdef PISO_PARITY_EN
    logic               par_q,   par_d;
`endif

    assign accept   = bus.load_valid && (state_q == IDLE);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state for FSM, shifter and bit counter; everything holds when clken is low.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = bus.din;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef PISO_PARITY_EN
                    par_d   = ^bus.din;
`endif
                end
            end
            SHIFT: begin
                if (bus.clken) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (last_bit) begin
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        // Counter parks at WIDTH-1 on the final bit instead of wrapping.
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                if (bus.clken) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // SO is a pure select of flop outputs, so it changes only on clock edges or reset.
`ifdef PISO_PARITY_EN
    assign bus.SO = (state_q == SHIFT)  ? shreg_q[WIDTH-1] :
                    (state_q == PARITY) ? par_q : 1'b0;
`else
    assign bus.SO = (state_q == SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
`endif
    assign bus.busy       = (state_q != IDLE);
    assign bus.load_ready = (state_q == IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer at WIDTH=8: stimulus queues expected bits,
// a negedge monitor pops one per shifting strobe and checks hold, idle and done.
module tb_piso_serializer;
    localparam int W = 8;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   gap = 1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    bit   done_due = 1'b0;

    piso_serializer_if #(.WIDTH(W)) bus ();

    piso_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Strobe generator: clken high once every `gap` cycles.
    initial begin
        int c = 0;
        bus.clken = 1'b0;
        forever begin
            @(posedge clk); #1;
            c++;
            bus.clken = ((c % gap) == 0);
        end
    end

    // Monitor: pops a bit on each shifting strobe, checks hold and done timing.
    initial begin
        logic prev_busy  = 1'b0;
        logic prev_shift = 1'b0;
        logic prev_so    = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy  = 1'b0;
                prev_shift = 1'b0;
            end else begin
                if (done_due) begin
                    chk("done_pulse", bus.done, 1'b1);
                    done_due = 1'b0;
                end else begin
                    chk("no_spurious_done", bus.done, 1'b0);
                end
                if (!bus.busy) begin
                    chk("idle_so", bus.SO, 1'b0);
                end else if (prev_busy && !prev_shift) begin
                    chk("so_hold", bus.SO, prev_so);
                end
                if (bus.busy && bus.clken) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_bit", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("so_bit", bus.SO, e.b);
                        if (e.last) done_due = 1'b1;
                    end
                end
                prev_busy  = bus.busy;
                prev_shift = bus.busy && bus.clken;
                prev_so    = bus.SO;
            end
        end
    end

    // Presents one word for one cycle and queues its expected serial bits.
    task automatic send(input logic [W-1:0] d, input logic par);
        exp_t e;
        @(posedge clk); #1;
        chk("ready_before_load", bus.load_ready, 1'b1);
        bus.load_valid = 1'b1;
        bus.din        = d;
        for (int i = W - 1; i >= 0; i--) begin
            e.b    = d[i];
`ifdef PISO_PARITY_EN
            e.last = 1'b0;
`else
            e.last = (i == 0);
`endif
            exp_q.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.b    = par;
        e.last = 1'b1;
        exp_q.push_back(e);
`else
        if (par) ; // trailer not built in this configuration
`endif
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        bus.din        = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || done_due || bus.busy) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("frame_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.din        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_so",    bus.SO,         1'b0);
        chk("rst_busy",  bus.busy,       1'b0);
        chk("rst_done",  bus.done,       1'b0);
        chk("rst_ready", bus.load_ready, 1'b1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset asserted while idle
        rst = 1'b1;
        #1;
        chk("idle_rst_so",    bus.SO,         1'b0);
        chk("idle_rst_ready", bus.load_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;

        // basic frame, continuous strobes
        gap = 1;
        send(8'hA5, 1'b0);
        wait_idle();

        // gapped strobes: each bit held three cycles
        gap = 3;
        send(8'h81, 1'b0);
        wait_idle();

        // second load while busy must be ignored
        gap = 1;
        send(8'h5A, 1'b0);
        @(posedge clk); #1;
        bus.load_valid = 1'b1;
        bus.din        = 8'hFF;
        #1;
        chk("ready_low_busy", bus.load_ready, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        bus.load_valid = 1'b0;
        bus.din        = '0;
        wait_idle();

        // reset after four bits of a frame
        send(8'hC3, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("bits_left_before_rst", exp_q.size(), W - 4 + ((`ifdef PISO_PARITY_EN 1 `else 0 `endif)));
        rst = 1'b1;
        #1;
        exp_q.delete();
        done_due = 1'b0;
        chk("abort_so",    bus.SO,         1'b0);
        chk("abort_busy",  bus.busy,       1'b0);
        chk("abort_done",  bus.done,       1'b0);
        chk("abort_ready", bus.load_ready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h3C, 1'b0);
        wait_idle();

`ifdef PISO_PARITY_EN
        send(8'h07, 1'b1);
        wait_idle();
        send(8'h03, 1'b0);
        wait_idle();
`endif

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Hard ceiling so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
